// File: rtl/blsync_tx_if.sv
// Handshake and output bundle for the blsync_tx 66b->64b transmit gearbox.
interface blsync_tx_if;
    logic [1:0]  tx_header;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] dout;
    logic        dout_valid;
    logic [5:0]  seq;
    logic        underrun;
    logic        hdr_err;

    modport master (
        output tx_header, tx_data, tx_valid,
        input  tx_ready, dout, dout_valid, seq, underrun, hdr_err
    );

    modport slave (
        input  tx_header, tx_data, tx_valid,
        output tx_ready, dout, dout_valid, seq, underrun, hdr_err
    );
endinterface

// File: rtl/blsync_tx.sv
// 10GBASE-R transmit gearbox: one 66-bit block per take, continuous 64-bit words out.
// Optional BLSYNC_TX_HDR_CHECK_EN replaces blocks with invalid sync headers by an error block.
module blsync_tx (
    input  logic        clk,
    input  logic        rst_n,
    blsync_tx_if.slave  bus
);

    typedef enum logic {
        S_START = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [5:0]  SEQ_LAST  = 6'd32;
    localparam logic [65:0] IDLE_BLK  = {64'h0000_0000_0000_001E, 2'b01};
    localparam logic [65:0] ERR_BLK   = {{8{7'h1E}}, 8'h1E, 2'b01};

    state_t       state, state_nxt;
    logic         run;
    logic         take;
    logic         hdr_bad;
    logic [5:0]   seq;
    logic [63:0]  residual;
    logic [63:0]  dout;
    logic         dout_valid;
    logic         underrun;
    logic         hdr_err;
    logic [65:0]  blk;
    logic [127:0] geared;

`ifdef BLSYNC_TX_HDR_CHECK_EN
    assign hdr_bad = (bus.tx_header == 2'b00) || (bus.tx_header == 2'b11);
`else
    assign hdr_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_START;
        else        state <= state_nxt;
    end

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (state == S_START) state_nxt = S_RUN;
    end

    assign run  = (state == S_RUN);
    assign take = run && (seq != SEQ_LAST);

    // Residual bits always occupy exactly 2*seq low bits, so the new block lands just above them.
    always_comb begin
        blk = IDLE_BLK;
        if (bus.tx_valid) begin
            blk = hdr_bad ? ERR_BLK : {bus.tx_data, bus.tx_header};
        end
        geared = ({62'd0, blk} << {seq, 1'b0}) | {64'd0, residual};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the residual register is reset too, so a mid-sequence reset drops any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq        <= '0;
            residual   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            underrun   <= 1'b0;
            hdr_err    <= 1'b0;
        end else begin
            dout_valid <= run;
            underrun   <= take && !bus.tx_valid;
            hdr_err    <= take && bus.tx_valid && hdr_bad;
            if (run) seq <= (seq == SEQ_LAST) ? 6'd0 : seq + 6'd1;
            if (take) begin
                dout     <= geared[63:0];
                residual <= geared[127:64];
            end else if (run) begin
                // Stall slot: drain the full 64-bit residual, take nothing.
                dout     <= residual;
                residual <= '0;
            end
        end
    end

    assign bus.tx_ready   = take;
    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.seq        = seq;
    assign bus.underrun   = underrun;
    assign bus.hdr_err    = hdr_err;

endmodule

// File: tb/tb_blsync_tx.sv
// Self-checking bench for blsync_tx: bit-serial queue model plus 66-bit block recovery from dout.
module tb_blsync_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    blsync_tx_if bus();

    blsync_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [65:0] IDLE_BLK = {64'h0000_0000_0000_001E, 2'b01};
    localparam logic [65:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E, 2'b01};
`ifdef BLSYNC_TX_HDR_CHECK_EN
    localparam bit HDR_CHK = 1'b1;
`else
    localparam bit HDR_CHK = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: serial bit stream in transmit order.
    bit          model_q[$];
    bit          rx_q[$];
    logic [65:0] sent_q[$];
    bit          active;
    int          mseq;
    logic [63:0] exp_dout;
    logic        exp_dv, exp_un, exp_he, exp_ready, obs_ready;
    logic [5:0]  exp_seq;

    function automatic bit hdr_invalid(input logic [1:0] h);
        return HDR_CHK && (h == 2'b00 || h == 2'b11);
    endfunction

    function automatic logic [65:0] expect_blk(input logic [1:0] h, input logic [63:0] d);
        return hdr_invalid(h) ? ERR_BLK : {d, h};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_clear();
        model_q.delete();
        rx_q.delete();
        sent_q.delete();
        active    = 1'b0;
        mseq      = 0;
        exp_dout  = '0;
        exp_dv    = 1'b0;
        exp_un    = 1'b0;
        exp_he    = 1'b0;
        exp_seq   = '0;
        exp_ready = 1'b0;
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, sample at next negedge.
    task automatic tick(input logic [1:0] h, input logic [63:0] d, input logic v);
        logic [65:0] blk;
        bus.tx_header = h;
        bus.tx_data   = d;
        bus.tx_valid  = v;
        exp_ready = active && (mseq != 32);
        obs_ready = bus.tx_ready;
        @(posedge clk);
        if (!active) begin
            active = 1'b1;
        end else begin
            exp_un = 1'b0;
            exp_he = 1'b0;
            if (exp_ready) begin
                if (!v) begin
                    blk    = IDLE_BLK;
                    exp_un = 1'b1;
                end else begin
                    blk    = expect_blk(h, d);
                    exp_he = hdr_invalid(h);
                end
                for (int i = 0; i < 66; i++) model_q.push_back(blk[i]);
            end
            for (int i = 0; i < 64; i++) exp_dout[i] = (model_q.size() > 0) ? model_q.pop_front() : 1'b0;
            exp_dv = 1'b1;
            mseq   = (mseq == 32) ? 0 : mseq + 1;
        end
        exp_seq = mseq[5:0];
        @(negedge clk);
        if (bus.dout_valid) for (int i = 0; i < 64; i++) rx_q.push_back(bus.dout[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.tx_header = 2'b00;
        bus.tx_data   = '0;
        bus.tx_valid  = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int lows;
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dout, bus.dout_valid, bus.seq, bus.tx_ready, bus.underrun, bus.hdr_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: dout=%h dv=%b seq=%0d ready=%b un=%b he=%b, required all 0",
                     bus.dout, bus.dout_valid, bus.seq, bus.tx_ready, bus.underrun, bus.hdr_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2'b10, rnd64(), 1'b1);
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_first_edge: got %b required 0", obs_ready);
        end
        lows = 0;
        for (int c = 0; c < 66; c++) begin
            tick(2'b10, rnd64(), 1'b1);
            if (obs_ready === 1'b0) lows++;
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL ready_cycle%0d: got %b required %b", c, obs_ready, exp_ready);
            end
            checks++;
            if (bus.seq !== exp_seq) begin
                errors++;
                $display("FAIL seq_cycle%0d: got %0d required %0d", c, bus.seq, exp_seq);
            end
        end
        checks++;
        if (lows != 2) begin
            errors++;
            $display("FAIL ready_low_count: got %0d required 2", lows);
        end
    endtask

    // Pop every complete 66-bit block recovered from dout and compare with what was sent.
    task automatic drain_recovered(input string tag);
        logic [65:0] got;
        logic [65:0] want;
        while (rx_q.size() >= 66 && sent_q.size() > 0) begin
            for (int i = 0; i < 66; i++) got[i] = rx_q.pop_front();
            want = sent_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s_recover: got %h required %h", tag, got, want);
            end
        end
    endtask

    task automatic test_stream(input bit with_reset, input int cycles, input string tag);
        logic [63:0] cnt;
        int          taken;
        if (with_reset) do_reset();
        cnt   = 64'h0123_4567_0000_0000;
        taken = 0;
        for (int c = 0; c < cycles; c++) begin
            tick(2'b10, cnt, 1'b1);
            if (obs_ready) begin
                sent_q.push_back({cnt, 2'b10});
                cnt++;
                taken++;
            end
            checks++;
            if (bus.dout !== exp_dout || bus.dout_valid !== exp_dv) begin
                errors++;
                $display("FAIL %s_dout_c%0d: got %h/%b required %h/%b", tag, c,
                         bus.dout, bus.dout_valid, exp_dout, exp_dv);
            end
            drain_recovered(tag);
        end
        checks++;
        if (taken != ((cycles - 1) / 33) * 32 + ((cycles - 1) % 33 > 32 ? 32 : (cycles - 1) % 33)) begin
            errors++;
            $display("FAIL %s_taken: got %0d blocks in %0d cycles", tag, taken, cycles);
        end
    endtask

    task automatic test_single();
        do_reset();
        tick(2'b10, rnd64(), 1'b1);
        tick(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        checks++;
        if (bus.dout !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL single_word0: got %h required FFFFFFFFFFFFFFFD", bus.dout);
        end
        tick(2'b10, 64'h0, 1'b1);
        checks++;
        if (bus.dout[3:0] !== 4'b1011) begin
            errors++;
            $display("FAIL single_residual: got %b required 1011", bus.dout[3:0]);
        end
        checks++;
        if (bus.dout !== exp_dout) begin
            errors++;
            $display("FAIL single_word1: got %h required %h", bus.dout, exp_dout);
        end
    endtask

    task automatic test_underrun();
        logic [65:0] idle;
        idle = IDLE_BLK;
        do_reset();
        tick(2'b10, rnd64(), 1'b1);
        repeat (5) tick(2'b10, rnd64(), 1'b1);
        checks++;
        if (bus.seq !== 6'd5) begin
            errors++;
            $display("FAIL underrun_seq: got %0d required 5", bus.seq);
        end
        tick(2'b10, rnd64(), 1'b0);
        checks++;
        if (bus.underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_pulse: got %b required 1", bus.underrun);
        end
        checks++;
        if (bus.dout[63:10] !== idle[53:0] || bus.dout !== exp_dout) begin
            errors++;
            $display("FAIL underrun_idle: got %h required %h", bus.dout, exp_dout);
        end
        tick(2'b10, rnd64(), 1'b1);
        checks++;
        if (bus.underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear: got %b required 0", bus.underrun);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick(2'b10, rnd64(), 1'b1);
        for (int c = 0; c < 40 && exp_seq != 6'd17; c++) tick(2'b10, rnd64(), 1'b1);
        checks++;
        if (bus.seq !== 6'd17) begin
            errors++;
            $display("FAIL midrst_seq: got %0d required 17", bus.seq);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dout, bus.dout_valid, bus.seq, bus.tx_ready, bus.underrun, bus.hdr_err} !== '0) begin
            errors++;
            $display("FAIL midrst_zero: dout=%h dv=%b seq=%0d ready=%b, required all 0",
                     bus.dout, bus.dout_valid, bus.seq, bus.tx_ready);
        end
        repeat (2) @(negedge clk);
        model_clear();
        rst_n = 1'b1;
        test_stream(1'b0, 80, "midrst");
    endtask

    task automatic test_hdr();
        logic [1:0]  h;
        logic [63:0] d;
        int          sent;
        do_reset();
        tick(2'b10, rnd64(), 1'b1);
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            h = (sent == 2) ? 2'b11 : 2'b10;
            d = rnd64();
            tick(h, d, 1'b1);
            if (obs_ready) begin
                sent_q.push_back(expect_blk(h, d));
                if (h == 2'b11) begin
                    checks++;
                    if (bus.hdr_err !== HDR_CHK) begin
                        errors++;
                        $display("FAIL hdr_err_pulse: got %b required %b", bus.hdr_err, HDR_CHK);
                    end
                end
                sent++;
            end
            drain_recovered("hdr");
        end
        checks++;
        if (bus.hdr_err !== 1'b0) begin
            errors++;
            $display("FAIL hdr_err_clear: got %b required 0", bus.hdr_err);
        end
    endtask

    task automatic test_random();
        logic [1:0]  h;
        logic [63:0] d;
        logic        v;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            h = 2'($urandom_range(0, 3));
            d = rnd64();
            v = ($urandom_range(0, 3) != 0);
            tick(h, d, v);
            checks++;
            if (obs_ready !== exp_ready || bus.seq !== exp_seq) begin
                errors++;
                $display("FAIL rand_ctrl_c%0d: ready=%b seq=%0d required ready=%b seq=%0d", c,
                         obs_ready, bus.seq, exp_ready, exp_seq);
            end
            checks++;
            if (bus.dout !== exp_dout || bus.dout_valid !== exp_dv) begin
                errors++;
                $display("FAIL rand_dout_c%0d: got %h/%b required %h/%b", c,
                         bus.dout, bus.dout_valid, exp_dout, exp_dv);
            end
            checks++;
            if (bus.underrun !== exp_un || bus.hdr_err !== exp_he) begin
                errors++;
                $display("FAIL rand_flags_c%0d: un=%b he=%b required un=%b he=%b", c,
                         bus.underrun, bus.hdr_err, exp_un, exp_he);
            end
        end
    endtask

    initial begin
        model_clear();
        bus.tx_header = 2'b00;
        bus.tx_data   = '0;
        bus.tx_valid  = 1'b0;
        test_reset();
        test_stream(1'b1, 3 * 33 + 6, "stream");
        test_single();
        test_underrun();
        test_mid_reset();
        test_hdr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
